// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
//   Round-robin arbiter that shares one resource among N requesters.
//   - Priority comes from a one-hot rotating ring pointer. Bit N-1 wraps to bit 0.
//   - A registered one-hot grant is issued and held until the winner drops its request.
//   - On release, the ring advances to one position past the winner.
//   - At least one idle cycle separates consecutive grants.
//
//   Optional feature: define RING_ARB_TIMEOUT_EN to force a release after MAX_HOLD grant
//   cycles. The forced release pulses timeout for one cycle. Without the macro a grant is
//   held indefinitely and timeout stays 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   en         allows new grants (no effect on a grant already issued)
//   req        level request per requester
//   gnt        one-hot grant, registered
//   gnt_valid  |gnt
//   gnt_idx    binary index of granted requester (0 when idle)
//   ptr        one-hot ring pointer, highest-priority position
//   timeout    one-cycle pulse on forced release
module ring_token_arbiter #(
    parameter int N        = 8,
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic [N-1:0]         ptr,
    output logic                 timeout
);

    localparam int IDX_W = $clog2(N);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Last hold count of a grant.
    // With the timeout enabled, a grant never counts past this value.
    // Saturating here is therefore indistinguishable from saturating at all-ones.
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [0:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  ptr_pos;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              owner_req;
    logic              force_rel;

    assign gnt_valid = |gnt;
    assign owner_req = req[gnt_idx];

    // Binary position of the one-hot ring pointer.
    always_comb begin
        ptr_pos = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ptr[i]) begin
                ptr_pos = IDX_W'(i);
            end
        end
    end

    // Search for the first requester starting at the pointer position.
    // The search wraps from N-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr_pos) + k) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef RING_ARB_TIMEOUT_EN
    // A request dropping on the limit cycle is an ordinary release, not a timeout.
    assign force_rel = owner_req && (hold_cnt == HOLD_LIMIT);
`else
    assign force_rel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            ptr      <= N'(1);
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        state    <= GRANT;
                        gnt      <= N'(1) << win_idx;
                        gnt_idx  <= win_idx;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || force_rel) begin
                        // Rotating the one-hot grant left gives "one past the winner".
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_idx  <= '0;
                        ptr      <= {gnt[N-2:0], gnt[N-1]};
                        hold_cnt <= '0;
                        timeout  <= force_rel;
                    end else if (hold_cnt != HOLD_LIMIT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Testbench for ring_token_arbiter.
//   N=8, MAX_HOLD=4.
//   Checks: reset state, a directed vector table, round-robin order,
//   en gating, the hold limit, asynchronous reset mid-grant, and
//   random traffic against a behavioural model.
module tb_ring_token_arbiter;

    localparam int N    = 8;
    localparam int MAXH = 4;
`ifdef RING_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [2:0]   gnt_idx;
    logic [N-1:0] ptr;
    logic         timeout;

    ring_token_arbiter #(.N(N), .HOLD_W(4), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(gnt),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .ptr(ptr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: granted requester number (-1 when idle), priority
    // position, cycles held so far, and the timeout flag.
    int m_g    = -1;
    int m_p    = 0;
    int m_hold = 0;
    bit m_to   = 1'b0;

    typedef struct {
        bit         en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic [7:0] ptr;
    } vec_t;

    vec_t tbl[12];

    function automatic bit bit_of(logic [N-1:0] r, int i);
        return ((r >> i) & 1) != 0;
    endfunction

    function automatic int first_from(int p, logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (bit_of(r, (p + k) % N)) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1; m_p = 0; m_hold = 0; m_to = 1'b0;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_g < 0) begin
            if (en && req != '0) begin
                m_g    = first_from(m_p, req);
                m_hold = 0;
            end
        end else if (!bit_of(req, m_g)) begin
            m_p = (m_g + 1) % N;
            m_g = -1;
        end else if (TO_EN && m_hold == MAXH - 1) begin
            m_p  = (m_g + 1) % N;
            m_g  = -1;
            m_to = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        logic [N-1:0] eg;
        eg = (m_g < 0) ? '0 : (N'(1) << m_g);
        chk({tag, "/gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "/gnt_valid"}, 32'(gnt_valid), (m_g >= 0) ? 32'd1 : 32'd0);
        chk({tag, "/gnt_idx"}, 32'(gnt_idx), (m_g < 0) ? 32'd0 : 32'(m_g));
        chk({tag, "/ptr"}, 32'(ptr), 32'd1 << m_p);
        chk({tag, "/timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with every requester active.
        rst_n = 1'b0; en = 1'b1; req = 8'hFF;
        model_reset();
        @(posedge clk); #1;
        chk("reset/gnt", 32'(gnt), 32'h0);
        chk("reset/gnt_valid", 32'(gnt_valid), 32'h0);
        chk("reset/gnt_idx", 32'(gnt_idx), 32'h0);
        chk("reset/ptr", 32'(ptr), 32'h01);
        chk("reset/timeout", 32'(timeout), 32'h0);
        req = '0; en = 1'b0;
        #2 rst_n = 1'b1;

        // Directed table, applied one vector per clock, starting from ptr=01.
        tbl[0]  = '{1'b1, 8'h81, 8'h01, 3'd0, 8'h01};
        tbl[1]  = '{1'b1, 8'h80, 8'h00, 3'd0, 8'h02};
        tbl[2]  = '{1'b1, 8'h80, 8'h80, 3'd7, 8'h02};
        tbl[3]  = '{1'b1, 8'h00, 8'h00, 3'd0, 8'h01};
        tbl[4]  = '{1'b0, 8'h10, 8'h00, 3'd0, 8'h01};
        tbl[5]  = '{1'b0, 8'h10, 8'h00, 3'd0, 8'h01};
        tbl[6]  = '{1'b1, 8'h10, 8'h10, 3'd4, 8'h01};
        tbl[7]  = '{1'b0, 8'h10, 8'h10, 3'd4, 8'h01};
        tbl[8]  = '{1'b0, 8'h14, 8'h10, 3'd4, 8'h01};
        tbl[9]  = '{1'b1, 8'h04, 8'h00, 3'd0, 8'h20};
        tbl[10] = '{1'b1, 8'h05, 8'h01, 3'd0, 8'h20};
        tbl[11] = '{1'b1, 8'h00, 8'h00, 3'd0, 8'h02};
        for (int i = 0; i < 12; i++) begin
            en  = tbl[i].en;
            req = tbl[i].req;
            tick("tbl");
            chk($sformatf("tbl%0d/gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d/idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d/ptr", i), 32'(ptr), 32'(tbl[i].ptr));
        end

        // Round-robin order with all requesting.
        // Each winner drops its request for one cycle.
        do_reset();
        en = 1'b1; req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick("rr");
            chk($sformatf("rr%0d/idx", g), 32'(gnt_idx), 32'(g % N));
            chk($sformatf("rr%0d/gnt", g), 32'(gnt), 32'd1 << (g % N));
            req = 8'hFF ^ (8'h01 << (g % N));
            tick("rr_idle");
            chk($sformatf("rr%0d/idle", g), 32'(gnt), 32'h0);
            req = 8'hFF;
        end

        // Hold limit.
        do_reset();
        en = 1'b1; req = 8'h04;
`ifdef RING_ARB_TIMEOUT_EN
        for (int c = 0; c < MAXH; c++) begin
            tick("to_hold");
            chk($sformatf("to_hold%0d/gnt", c), 32'(gnt), 32'h04);
            chk($sformatf("to_hold%0d/timeout", c), 32'(timeout), 32'h0);
        end
        tick("to_rel");
        chk("to_rel/gnt", 32'(gnt), 32'h0);
        chk("to_rel/timeout", 32'(timeout), 32'h1);
        chk("to_rel/ptr", 32'(ptr), 32'h08);
        tick("to_regrant");
        chk("to_regrant/gnt", 32'(gnt), 32'h04);
        chk("to_regrant/timeout", 32'(timeout), 32'h0);
`else
        for (int c = 0; c < 22; c++) begin
            tick("hold");
            chk($sformatf("hold%0d/gnt", c), 32'(gnt), 32'h04);
            chk($sformatf("hold%0d/timeout", c), 32'(timeout), 32'h0);
        end
`endif
        req = '0;
        tick("hold_end");

        // Asynchronous reset in the middle of a grant.
        // The pointer is first moved away from 01.
        do_reset();
        en = 1'b1; req = 8'h02;
        tick("ar_g1");
        req = 8'h00;
        tick("ar_r1");
        chk("ar/ptr_moved", 32'(ptr), 32'h04);
        req = 8'h20;
        tick("ar_g2");
        tick("ar_h2");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar/gnt", 32'(gnt), 32'h0);
        chk("ar/gnt_valid", 32'(gnt_valid), 32'h0);
        chk("ar/gnt_idx", 32'(gnt_idx), 32'h0);
        chk("ar/ptr", 32'(ptr), 32'h01);
        chk("ar/timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 15) == 0) req = '0;
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
